// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and encodings for the RISC datapath controller
// Contents: state_t (controller states), opcode/op field values,
//           nsel/vsel select encodings, instruction classification helpers.
package risc_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_WRITE_IMM = 3'd2,
        S_GET_A     = 3'd3,
        S_GET_B     = 3'd4,
        S_ALU       = 3'd5,
        S_WRITE_REG = 3'd6
    } state_t;

    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_ALU = 3'b101;

    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] NSEL_RN = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RM = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'd0;
    localparam logic [1:0] VSEL_PC    = 2'd1;
    localparam logic [1:0] VSEL_IMM8  = 2'd2;
    localparam logic [1:0] VSEL_MDATA = 2'd3;

    // Instructions that pass a single operand through the shifter with A forced to 0.
    function automatic logic is_unary(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OP_MOV && op == MOV_REG) || (opc == OP_ALU && op == ALU_MVN);
    endfunction

    function automatic logic is_cmp(input logic [2:0] opc, input logic [1:0] op);
        return opc == OP_ALU && op == ALU_CMP;
    endfunction

endpackage

// File: rtl/risc_controller.sv
// rtl/risc_controller.sv - Moore FSM sequencing the RISC register/ALU datapath
// Ports: clk, reset_n (async active-low); s start request, opcode/op decoder
//        fields; w ready, nsel register select, loada/loadb/loadc/loads load
//        enables, asel/bsel ALU input selects, vsel writeback select, write
//        register-file strobe, illegal undefined-instruction pulse.
module risc_controller
    import risc_pkg::*;
#(
    parameter int VSEL_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s,
    input  logic [2:0]        opcode,
    input  logic [1:0]        op,
    output logic              w,
    output logic [1:0]        nsel,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [VSEL_W-1:0] vsel,
    output logic              write,
    output logic              illegal
);

    state_t     state, state_next;
    logic [2:0] opc_q;
    logic [1:0] op_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_WAIT;
            opc_q <= 3'b000;
            op_q  <= 2'b00;
        end else begin
            state <= state_next;
            // Fields are captured once at accept; the decoder may move on afterwards.
            if (state == S_WAIT && s) begin
                opc_q <= opcode;
                op_q  <= op;
            end
        end
    end

    always_comb begin
        state_next = S_WAIT;
        case (state)
            S_WAIT:      state_next = s ? S_DECODE : S_WAIT;
            S_DECODE: begin
                case ({opc_q, op_q})
                    {OP_MOV, MOV_IMM}: state_next = S_WRITE_IMM;
                    {OP_MOV, MOV_REG}: state_next = S_GET_B;
                    {OP_ALU, ALU_ADD},
                    {OP_ALU, ALU_CMP},
                    {OP_ALU, ALU_AND}: state_next = S_GET_A;
                    {OP_ALU, ALU_MVN}: state_next = S_GET_B;
                    default:           state_next = S_WAIT;
                endcase
            end
            S_WRITE_IMM: state_next = S_WAIT;
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_ALU;
            S_ALU:       state_next = is_cmp(opc_q, op_q) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_RN;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        vsel    = VSEL_W'(VSEL_C);
        write   = 1'b0;
        illegal = 1'b0;
        case (state)
            S_WAIT: w = 1'b1;
            S_DECODE: begin
                // Flag anything the dispatch above would not route to a datapath state.
                case ({opc_q, op_q})
                    {OP_MOV, MOV_IMM}, {OP_MOV, MOV_REG},
                    {OP_ALU, ALU_ADD}, {OP_ALU, ALU_CMP},
                    {OP_ALU, ALU_AND}, {OP_ALU, ALU_MVN}: illegal = 1'b0;
                    default:                              illegal = 1'b1;
                endcase
            end
            S_WRITE_IMM: begin
                vsel  = VSEL_W'(VSEL_IMM8);
                write = 1'b1;
            end
            S_GET_A: loada = 1'b1;
            S_GET_B: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_ALU: begin
                asel  = is_unary(opc_q, op_q);
                loadc = !is_cmp(opc_q, op_q);
                loads = is_cmp(opc_q, op_q);
            end
            S_WRITE_REG: begin
                nsel  = NSEL_RD;
                write = 1'b1;
            end
            default: w = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_risc_controller.sv
// tb/tb_risc_controller.sv - self-checking bench for risc_controller
module tb_risc_controller;

    typedef struct packed {
        logic       w;
        logic [1:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       illegal;
    } ctl_t;

    localparam ctl_t IDLE = ctl_t'(13'h1000);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write, illegal;
    logic [1:0] nsel, vsel;

    int total = 0;
    int bad = 0;

    risc_controller #(.VSEL_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Model: an accepted instruction expands into its list of per-cycle control words.
    ctl_t cur = IDLE;
    ctl_t q[$];

    task automatic push_sched(input logic [2:0] oc, input logic [1:0] o);
        ctl_t dec, ga, gb, al, wr, wi;
        dec = '0;
        ga = '0; ga.loada = 1'b1;
        gb = '0; gb.nsel = 2'b10; gb.loadb = 1'b1;
        al = '0; al.loadc = 1'b1;
        wr = '0; wr.nsel = 2'b01; wr.write = 1'b1;
        wi = '0; wi.vsel = 2'd2; wi.write = 1'b1;
        if (oc == 3'b110 && o == 2'b10) begin
            q.push_back(dec); q.push_back(wi);
        end else if ((oc == 3'b110 && o == 2'b00) || (oc == 3'b101 && o == 2'b11)) begin
            al.asel = 1'b1;
            q.push_back(dec); q.push_back(gb); q.push_back(al); q.push_back(wr);
        end else if (oc == 3'b101 && o == 2'b01) begin
            al.loadc = 1'b0; al.loads = 1'b1;
            q.push_back(dec); q.push_back(ga); q.push_back(gb); q.push_back(al);
        end else if (oc == 3'b101 && (o == 2'b00 || o == 2'b10)) begin
            q.push_back(dec); q.push_back(ga); q.push_back(gb); q.push_back(al); q.push_back(wr);
        end else begin
            dec.illegal = 1'b1;
            q.push_back(dec);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            cur = IDLE;
        end else begin
            if (cur.w && s) push_sched(opcode, op);
            if (q.size() > 0) cur = q.pop_front();
            else cur = IDLE;
        end
    end

    always @(negedge clk) begin
        ctl_t got;
        got = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal};
        total++;
        if (got !== cur) begin
            bad++;
            $display("FAIL ctl_word t=%0t got=%h exp=%h", $time, got, cur);
        end
        total++;
        if ((int'(loada) + int'(loadb) + int'(loadc) + int'(write)) > 1 || (write && loads)) begin
            bad++;
            $display("FAIL strobe_overlap t=%0t got=%h", $time, got);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one instruction and count the cycles the controller is busy.
    task automatic issue(input string nm, input logic [2:0] oc, input logic [1:0] o, input int exp_lat);
        int cnt;
        opcode = oc; op = o; s = 1'b1;
        tick();
        s = 1'b0;
        cnt = 0;
        while (w !== 1'b1 && cnt < 30) begin
            cnt++;
            tick();
        end
        chk(nm, cnt, exp_lat);
    endtask

    initial begin
        int wh, ah;
        #1;
        chk("reset_w", w, 1);
        chk("reset_write", write, 0);
        chk("reset_nsel", nsel, 0);
        chk("reset_vsel", vsel, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // MOV R3,#0x42
        opcode = 3'b110; op = 2'b10; s = 1'b1;
        tick();
        s = 1'b0;
        chk("mov_dec_w", w, 0);
        chk("mov_dec_write", write, 0);
        tick();
        chk("mov_wr_write", write, 1);
        chk("mov_wr_vsel", vsel, 2);
        chk("mov_wr_nsel", nsel, 0);
        tick();
        chk("mov_done_w", w, 1);

        issue("lat_add", 3'b101, 2'b00, 5);
        issue("lat_and", 3'b101, 2'b10, 5);
        issue("lat_cmp", 3'b101, 2'b01, 4);
        issue("lat_movreg", 3'b110, 2'b00, 4);
        issue("lat_mvn", 3'b101, 2'b11, 4);
        issue("lat_movimm", 3'b110, 2'b10, 2);
        issue("lat_ill_111", 3'b111, 2'b00, 1);
        issue("lat_ill_110_11", 3'b110, 2'b11, 1);

        // Illegal opcode, then decoder fields change during S_DECODE
        opcode = 3'b000; op = 2'b00; s = 1'b1;
        tick();
        s = 1'b0; opcode = 3'b110; op = 2'b10;
        chk("ill_pulse", illegal, 1);
        chk("ill_write", write, 0);
        tick();
        chk("ill_w_back", w, 1);
        chk("ill_cleared", illegal, 0);
        tick();

        // Reset asserted mid-ADD in S_GET_B
        opcode = 3'b101; op = 2'b00; s = 1'b1;
        tick();
        s = 1'b0;
        tick();
        chk("rst_geta", loada, 1);
        tick();
        chk("rst_getb", loadb, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_w", w, 1);
        chk("rst_async_loadb", loadb, 0);
        chk("rst_async_write", write, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        wh = 0;
        repeat (6) begin
            tick();
            if (w === 1'b1 && write === 1'b0) wh++;
        end
        chk("rst_idle_cycles", wh, 6);

        // s held high: back-to-back MVN, busy-time opcode noise ignored
        opcode = 3'b101; op = 2'b11; s = 1'b1;
        wh = 0; ah = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (w === 1'b1) begin
                wh++;
                opcode = 3'b101; op = 2'b11;
            end else begin
                opcode = 3'($urandom_range(0, 7));
                op = 2'($urandom_range(0, 3));
            end
            if (asel === 1'b1) ah++;
        end
        s = 1'b0;
        chk("b2b_w_high", wh, 3);
        chk("b2b_asel", ah, 3);
        repeat (6) tick();
        chk("final_idle", w, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
